// File: rtl/debug_step_ctrl_if.sv
// Debug run-control bundle: board debug inputs and core retire status in,
// pipeline advance enable and halt/breakpoint/interrupt status out.
interface debug_step_ctrl_if #(
  parameter int NUM_BP = 2,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 32
);
  logic                     debug_en;
  logic                     debug_step;
  logic [7:0]               step_count;
  logic [NUM_BP-1:0]        bp_en;
  logic [NUM_BP*PC_W-1:0]   bp_addr;
  logic [PC_W-1:0]          pc;
  logic                     inst_retire;
  logic                     interrupter;
  logic                     cpu_en;
  logic                     halted;
  logic [NUM_BP-1:0]        bp_hit;
  logic                     irq_out;
  logic [CNT_W-1:0]         retire_cnt;

  modport master (
    output debug_en, debug_step, step_count, bp_en, bp_addr, pc, inst_retire, interrupter,
    input  cpu_en, halted, bp_hit, irq_out, retire_cnt
  );

  modport slave (
    input  debug_en, debug_step, step_count, bp_en, bp_addr, pc, inst_retire, interrupter,
    output cpu_en, halted, bp_hit, irq_out, retire_cnt
  );
endinterface

// File: rtl/debug_step_ctrl.sv
// Run controller for the core pipeline: free run, N-instruction stepping,
// PC breakpoints and interrupt masking while halted or stepping.
module debug_step_ctrl #(
  parameter int NUM_BP      = 2,
  parameter int PC_W        = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  debug_step_ctrl_if.slave dbg
);

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  step_sync;
  logic [SYNC_STAGES-1:0]  irq_sync;
  logic                    step_prev;
  logic                    step_req;
  logic [7:0]              remain;
  logic                    skip;
  logic                    halted_r;
  logic [NUM_BP-1:0]       bp_hit_r;
  logic [CNT_W-1:0]        retire_cnt_r;
  logic [NUM_BP-1:0]       match_vec;
  logic                    any_match;
  logic                    cpu_en_s;
  logic                    retire;

  // Two-flop-or-deeper synchronisers for the asynchronous button and interrupt, plus step edge flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_sync <= '0;
      irq_sync  <= '0;
      step_prev <= 1'b0;
    end else begin
      step_sync <= {step_sync[SYNC_STAGES-2:0], dbg.debug_step};
      irq_sync  <= {irq_sync[SYNC_STAGES-2:0], dbg.interrupter};
      step_prev <= step_sync[SYNC_STAGES-1];
    end
  end

  assign step_req = step_sync[SYNC_STAGES-1] & ~step_prev;

  // Per-comparator PC match; suppressed while stepping off the PC we halted on
  always_comb begin
    match_vec = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      match_vec[i] = dbg.bp_en[i] && (dbg.pc == dbg.bp_addr[i*PC_W +: PC_W]) && !skip;
    end
  end

  assign any_match = |match_vec;
  // A matching PC must not retire, so the enable drops in the same cycle
  assign cpu_en_s  = (state == STEP) || ((state == RUN) && !any_match);
  assign retire    = dbg.inst_retire && cpu_en_s;

  // Run-control state machine with retire counter and breakpoint status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= HALT;
      halted_r     <= 1'b1;
      bp_hit_r     <= '0;
      remain       <= 8'd0;
      skip         <= 1'b0;
      retire_cnt_r <= '0;
    end else begin
      if (retire) begin
        retire_cnt_r <= retire_cnt_r + CNT_W'(1);
        skip         <= 1'b0;
      end
      case (state)
        HALT: begin
          if (!dbg.debug_en) begin
            state    <= RUN;
            halted_r <= 1'b0;
            skip     <= 1'b1;
            bp_hit_r <= '0;
          end else if (step_req) begin
            state    <= STEP;
            halted_r <= 1'b0;
            skip     <= 1'b1;
            bp_hit_r <= '0;
            remain   <= (dbg.step_count == 8'd0) ? 8'd1 : dbg.step_count;
          end
        end
        STEP: begin
          if (retire) begin
            remain <= remain - 8'd1;
          end
          if (!dbg.debug_en) begin
            state <= RUN;
          end else if (retire && (remain == 8'd1)) begin
            state    <= HALT;
            halted_r <= 1'b1;
          end
        end
        RUN: begin
          if (any_match) begin
            state    <= HALT;
            halted_r <= 1'b1;
            bp_hit_r <= match_vec;
          end else if (dbg.debug_en) begin
            state    <= HALT;
            halted_r <= 1'b1;
          end
        end
        default: begin
          state    <= HALT;
          halted_r <= 1'b1;
        end
      endcase
    end
  end

  assign dbg.cpu_en     = cpu_en_s;
  assign dbg.halted     = halted_r;
  assign dbg.bp_hit     = bp_hit_r;
  assign dbg.retire_cnt = retire_cnt_r;
  // Level-only request: masked cycles are not remembered
  assign dbg.irq_out    = irq_sync[SYNC_STAGES-1] && !halted_r && (state != STEP);

endmodule

// File: doc/debug_step_ctrl.md
# debug_step_ctrl

Parametrised run-control unit between the board debug inputs and the MIPS core's pipeline enable. It replaces ad-hoc free-run or single-step clock gating with a synthesisable controller. The controller supports four behaviours: free run, N-instruction stepping from a synchronised step button, NUM_BP PC breakpoints, and interrupt holding while halted. It drives the core's global advance enable and exposes halt and breakpoint status to the debug read-out logic.

## Interface
- NUM_BP, 2: number of PC breakpoint comparators (1..8)
- PC_W, 32: PC width
- SYNC_STAGES, 2: synchroniser depth for debug_step and interrupter (>=2)
- CNT_W, 32: retired-instruction counter width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- debug_en  in  1  1 = debug (halt/step) mode, 0 = free run; synchronous to clk
- debug_step  in  1  asynchronous step button level; each rising edge requests one step
- step_count  in  8  instructions per step request; 0 is treated as 1; sampled on step acceptance
- bp_en  in  NUM_BP  per-breakpoint enable
- bp_addr  in  NUM_BP*PC_W  breakpoint PCs; comparator i uses bits [i*PC_W +: PC_W]
- pc  in  PC_W  PC of the instruction the core retires when cpu_en=1
- inst_retire  in  1  core pulse: one instruction retired this cycle (ignored when cpu_en=0)
- interrupter  in  1  asynchronous external interrupt request, level
- cpu_en  out  1  pipeline advance enable
- halted  out  1  registered, 1 in HALT state
- bp_hit  out  NUM_BP  sticky one-hot-or-more: breakpoints matching at the halting cycle
- irq_out  out  1  interrupt to core
- retire_cnt  out  CNT_W  instructions retired since reset, wraps modulo 2^CNT_W

## Operation
- States: HALT, RUN, STEP. Reset -> HALT.
- Step edge: debug_step passes SYNC_STAGES flops plus one edge flop; step_req = sync & ~prev (one-cycle pulse).
- HALT: cpu_en=0.
  - debug_en=0 -> RUN.
  - Otherwise step_req -> STEP with remain = (step_count==0 ? 1 : step_count).
  - On leaving HALT: set skip=1 and clear bp_hit.
- STEP: cpu_en=1. Each inst_retire decrements remain. Retire with remain==1 -> HALT next cycle. Breakpoints are not evaluated in STEP. debug_en=0 -> RUN.
- RUN:
  - bp_match = OR over i of (bp_en[i] & pc==bp_addr[i]) & ~skip.
  - cpu_en = ~bp_match (combinational).
  - bp_match -> HALT next cycle, bp_hit <= per-comparator match vector.
  - debug_en=1 with no match -> HALT next cycle; cpu_en stays 1 this cycle.
- skip clears on the first inst_retire while cpu_en=1. This lets the core step or run off a breakpoint PC.
- step_req outside HALT is dropped, never queued.
- Interrupts: interrupter is synchronised into irq_sync.
  - irq_out = irq_sync & ~halted & (state!=STEP). Requests are masked while halted or stepping and are never lost while the level persists.
  - Masked edges are not latched; the request is level-only.
- retire_cnt increments on inst_retire & cpu_en.

## Timing
- Reset values: state=HALT, cpu_en=0, halted=1, bp_hit=0, irq_out=0, retire_cnt=0, remain=0, skip=0, all sync flops=0.
- debug_step rising at the pin -> STEP entered SYNC_STAGES+1 rising edges later -> cpu_en=1 in that cycle.
- Final step retire in cycle t -> halted=1 and cpu_en=0 from cycle t+1.
- Breakpoint match in cycle t -> cpu_en=0 in t (no retire of the matching PC), halted=1 and bp_hit valid from t+1.
- Simultaneous debug_en=0 and step_req in HALT: RUN wins.
- Reset mid-step or mid-run: immediate HALT, counters cleared, pending step lost.
- remain width is 8 bits; no wrap, because decrement stops at 1 -> HALT.

## Test plan
- Reset with debug_en=1, then one debug_step edge with step_count=0 -> after SYNC_STAGES+1 cycles cpu_en=1 for exactly 1 retire; halted=1; retire_cnt=1.
- step_count=5, one edge, retires every other cycle -> exactly 5 retires, halt the cycle after the 5th; a second edge mid-step is dropped (retire_cnt=5).
- debug_en=0, bp_en=2'b10, bp_addr[1]=0x0040_0010, pc sweeps by 4 -> cpu_en=0 in the cycle pc=0x0040_0010; halted=1, bp_hit=2'b10.
- From that breakpoint, drop debug_en to 0 again -> the PC at 0x0040_0010 retires (skip) and run continues; bp_hit clears.
- interrupter=1 while halted -> irq_out=0. Release via debug_en=0 -> irq_out=1 within 1 cycle of entering RUN.
- Assert rst asynchronously during STEP with remain=3 -> cpu_en and irq_out drop immediately; after release halted=1 and retire_cnt=0.
